// File: rtl/vib_sample_framer.sv
// ---------------------------------------------------------------------------
// vib_sample_framer
//
// Upstream feeder for the UART driver stage. Sums 2^DECIM_LOG2 consecutive
// unsigned ADC samples into one word, tags the sum with its index inside
// the frame, and presents it on i_data with a one-cycle UART_send strobe.
// new_frame accompanies the strobe of every idx 0 word.
//
// Ports:
//   sys_clock    in   1      system clock, rising edge
//   reset        in   1      synchronous, active-high; clears all state
//   enable       in   1      capture arm (level)
//   adc_valid    in   1      adc_data valid this cycle
//   adc_data     in   ADC_W  unsigned sample
//   test_mode    in   1      (only with VIB_FRAMER_TEST_PATTERN_EN) ramp
//                            counter replaces the sum field
//   i_data       out  22     {idx, sum}
//   UART_send    out  1      one-cycle strobe: i_data holds a new word
//   new_frame    out  1      strobe coincident with UART_send on idx 0
//   busy         out  1      high in RUN or DRAIN
//   frame_count  out  8      completed frames, wraps 255 -> 0
//
// Optional feature macro: VIB_FRAMER_TEST_PATTERN_EN
// ---------------------------------------------------------------------------
module vib_sample_framer #(
    parameter int ADC_W      = 12,
    parameter int DECIM_LOG2 = 4,
    parameter int IDX_W      = 6,
    parameter int FRAME_LEN  = 64
) (
    input  logic             sys_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
`ifdef VIB_FRAMER_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    output logic [21:0]      i_data,
    output logic             UART_send,
    output logic             new_frame,
    output logic             busy,
    output logic [7:0]       frame_count
);

    localparam int SUM_W  = ADC_W + DECIM_LOG2;
    localparam int WORD_W = 22;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [DECIM_LOG2-1:0] LAST_CNT = '1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Parameter sanity: the word layout must fill exactly 22 bits.
    if (IDX_W + ADC_W + DECIM_LOG2 != WORD_W) begin : g_bad_word_width
        $error("vib_sample_framer: IDX_W + ADC_W + DECIM_LOG2 must equal 22");
    end
    if (FRAME_LEN < 1 || FRAME_LEN > (1 << IDX_W)) begin : g_bad_frame_len
        $error("vib_sample_framer: FRAME_LEN must be in 1..2^IDX_W");
    end
    if (DECIM_LOG2 < 1) begin : g_bad_decim
        $error("vib_sample_framer: DECIM_LOG2 must be at least 1");
    end

    function automatic logic [WORD_W-1:0] pack_word(input logic [IDX_W-1:0] idx,
                                                    input logic [SUM_W-1:0] field);
        return {idx, field};
    endfunction

    logic [1:0]            state_q, state_d;
    logic [SUM_W-1:0]      acc_q, acc_d;
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_W-1:0]     data_q, data_d;
    logic                  send_q, send_d;
    logic                  nf_q, nf_d;
    logic [7:0]            fcnt_q, fcnt_d;

    logic                  accept;
    logic                  last_sample;
    logic                  last_word;
    logic [SUM_W-1:0]      sum_next;
    logic [SUM_W-1:0]      word_field;

    assign accept      = adc_valid && (state_q != ST_IDLE);
    assign last_sample = accept && (cnt_q == LAST_CNT);
    assign last_word   = last_sample && (idx_q == LAST_IDX);
    // Exact width: 2^DECIM_LOG2 samples of ADC_W bits cannot exceed SUM_W.
    assign sum_next    = acc_q + SUM_W'(adc_data);

`ifdef VIB_FRAMER_TEST_PATTERN_EN
    logic [SUM_W-1:0] ramp_q, ramp_d;

    always_comb begin
        ramp_d = ramp_q;
        if (state_q == ST_IDLE && enable) begin
            ramp_d = '0;
        end else if (last_sample) begin
            ramp_d = ramp_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end

    assign word_field = test_mode ? ramp_q : sum_next;
`else
    assign word_field = sum_next;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        send_d  = 1'b0;
        nf_d    = 1'b0;
        fcnt_d  = fcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    acc_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // With nothing accumulated at a frame boundary there is
                    // no frame in progress, so drop straight back to idle.
                    if (last_word || (!accept && idx_q == '0 && cnt_q == '0)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (last_word) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            if (last_sample) begin
                // Word complete: emit and restart the accumulator on the
                // same edge so the very next sample is not lost.
                data_d = pack_word(idx_q, word_field);
                send_d = 1'b1;
                nf_d   = (idx_q == '0);
                acc_d  = '0;
                cnt_d  = '0;
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    fcnt_d = fcnt_q + 8'd1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                acc_d = sum_next;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            send_q  <= 1'b0;
            nf_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            send_q  <= send_d;
            nf_q    <= nf_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign i_data      = data_q;
    assign UART_send   = send_q;
    assign new_frame   = nf_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_vib_sample_framer.sv
// ---------------------------------------------------------------------------
// tb_vib_sample_framer
//
// Self-checking bench for vib_sample_framer. A word-level reference model
// (running sum, sample count, frame index) is advanced once per clock edge
// and every DUT output is compared each cycle; directed scenarios also check
// captured DUT words against fixed constants.
// ---------------------------------------------------------------------------
module tb_vib_sample_framer;

    localparam int FRAME_LEN = 64;
    localparam int DECIM_N   = 16;

    logic        sys_clock;
    logic        reset;
    logic        enable;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        tm;
    logic [21:0] i_data;
    logic        UART_send;
    logic        new_frame;
    logic        busy;
    logic [7:0]  frame_count;

    vib_sample_framer dut (
        .sys_clock   (sys_clock),
        .reset       (reset),
        .enable      (enable),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
`ifdef VIB_FRAMER_TEST_PATTERN_EN
        .test_mode   (tm),
`endif
        .i_data      (i_data),
        .UART_send   (UART_send),
        .new_frame   (new_frame),
        .busy        (busy),
        .frame_count (frame_count)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    int n_chk  = 0;
    int n_fail = 0;
    int cycle  = 0;

    // Reference model state
    logic        m_active;
    int          m_sum;
    int          m_n;
    int          m_idx;
    int          m_fc;
    int          m_ramp;
    logic [21:0] m_word;
    logic        m_send;
    logic        m_nf;

    // Words observed on the DUT outputs
    logic [21:0] dut_words[$];
    logic        dut_nf[$];
    int          dut_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic v, input logic [11:0] d);
        m_send = 1'b0;
        m_nf   = 1'b0;
        if (r) begin
            m_active = 1'b0;
            m_sum    = 0;
            m_n      = 0;
            m_idx    = 0;
            m_fc     = 0;
            m_ramp   = 0;
            m_word   = '0;
        end else if (!m_active) begin
            if (e) begin
                m_active = 1'b1;
                m_sum    = 0;
                m_n      = 0;
                m_idx    = 0;
                m_ramp   = 0;
            end
        end else begin
            if (v) begin
                m_sum = m_sum + int'(d);
                m_n   = m_n + 1;
                if (m_n == DECIM_N) begin
                    m_word = {6'(m_idx), (tm ? 16'(m_ramp) : 16'(m_sum))};
                    m_send = 1'b1;
                    m_nf   = (m_idx == 0);
                    m_ramp = (m_ramp + 1) % 65536;
                    if (m_idx == FRAME_LEN - 1) begin
                        m_idx = 0;
                        m_fc  = (m_fc + 1) % 256;
                    end else begin
                        m_idx = m_idx + 1;
                    end
                    m_sum = 0;
                    m_n   = 0;
                end
            end
            // Capture ends once enable is low and no frame is in progress.
            if (!e && m_idx == 0 && m_n == 0) m_active = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic v, input logic [11:0] d);
        @(negedge sys_clock);
        reset     = r;
        enable    = e;
        adc_valid = v;
        adc_data  = d;
        @(posedge sys_clock);
        model_edge(r, e, v, d);
        cycle++;
        #1;
        chk("send",  {31'd0, UART_send}, {31'd0, m_send});
        chk("nf",    {31'd0, new_frame}, {31'd0, m_nf});
        chk("data",  {10'd0, i_data},    {10'd0, m_word});
        chk("busy",  {31'd0, busy},      {31'd0, m_active});
        chk("fcnt",  {24'd0, frame_count}, 32'(m_fc));
        if (UART_send === 1'b1) begin
            dut_words.push_back(i_data);
            dut_nf.push_back(new_frame);
            dut_cyc.push_back(cycle);
        end
    endtask

    task automatic clear_capture();
        dut_words.delete();
        dut_nf.delete();
        dut_cyc.delete();
    endtask

    initial begin
        logic [21:0] w;
        logic        en_r;
        int          s0;

        reset     = 1'b1;
        enable    = 1'b0;
        adc_valid = 1'b0;
        adc_data  = '0;
        tm        = 1'b0;
        model_edge(1'b1, 1'b0, 1'b0, 12'd0);

        // Reset state
        step(1, 0, 0, 0);
        step(1, 1, 1, 12'hABC);
        chk("rst_data", {10'd0, i_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fcnt", {24'd0, frame_count}, 32'd0);
        // Idle with enable low ignores samples
        for (int i = 0; i < 20; i++) step(0, 0, 1, 12'hFFF);
        chk("idle_words", 32'(dut_words.size()), 32'd0);

        // Constant 0x0F0, valid every cycle, 65 words
        clear_capture();
        s0 = cycle;
        for (int i = 0; i < 1 + DECIM_N * 65 + 2; i++) step(0, 1, 1, 12'h0F0);
        chk("s1_lat",  32'(dut_cyc[0] - s0), 32'd17);
        chk("s1_w0",   {10'd0, dut_words[0]},  32'h000F00);
        chk("s1_nf0",  {31'd0, dut_nf[0]},     32'd1);
        chk("s1_w1",   {10'd0, dut_words[1]},  32'h010F00);
        chk("s1_nf1",  {31'd0, dut_nf[1]},     32'd0);
        chk("s1_w63",  {10'd0, dut_words[63]}, 32'h3F0F00);
        chk("s1_w64",  {10'd0, dut_words[64]}, 32'h000F00);
        chk("s1_nf64", {31'd0, dut_nf[64]},    32'd1);
        chk("s1_fcnt", {24'd0, frame_count},   32'd1);

        // Full-scale samples with alternating valid: no wrap, 32-cycle spacing
        step(1, 0, 0, 0);
        clear_capture();
        for (int i = 0; i < 1 + 32 * 4 + 4; i++) step(0, 1, i[0], 12'hFFF);
        w = dut_words[1];
        chk("s2_sum",  {16'd0, w[15:0]}, 32'h0000FFF0);
        chk("s2_w0",   {10'd0, dut_words[0]}, 32'h00FFF0);
        chk("s2_gap",  32'(dut_cyc[2] - dut_cyc[1]), 32'd32);

        // Enable dropped after word idx 10: frame still completes
        step(1, 0, 0, 0);
        clear_capture();
        for (int i = 0; i < 400 && dut_words.size() < 11; i++) step(0, 1, 1, 12'($urandom));
        chk("s3_armed", 32'(dut_words.size()), 32'd11);
        for (int i = 0; i < DECIM_N * 53 + 100; i++) step(0, 0, 1, 12'($urandom));
        chk("s3_count", 32'(dut_words.size()), 32'd64);
        w = (dut_words.size() > 0) ? dut_words[dut_words.size() - 1] : 22'h0;
        chk("s3_lastidx", {26'd0, w[21:16]}, 32'd63);
        chk("s3_busy", {31'd0, busy}, 32'd0);
        chk("s3_fcnt", {24'd0, frame_count}, 32'd1);

        // Reset after 7 samples of word idx 3
        step(1, 0, 0, 0);
        for (int i = 0; i < 300 && !(m_idx == 3 && m_n == 7); i++) step(0, 1, 1, 12'($urandom));
        chk("s4_pos", 32'(m_idx * 100 + m_n), 32'd307);
        step(1, 1, 1, 12'h123);
        chk("s4_data", {10'd0, i_data}, 32'd0);
        chk("s4_send", {31'd0, UART_send}, 32'd0);
        chk("s4_busy", {31'd0, busy}, 32'd0);
        clear_capture();
        // Sample on the enabling edge is ignored; the next 16 sum to 0x6C8.
        for (int k = 0; k < 20; k++) step(0, 1, 1, 12'(100 + k));
        chk("s4_w0",  {10'd0, dut_words[0]}, 32'h0006C8);
        chk("s4_nf0", {31'd0, dut_nf[0]}, 32'd1);

        // Randomized traffic including enable toggles and rare resets
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            step(($urandom_range(0, 999) == 0), en_r, ($urandom_range(0, 3) != 0), 12'($urandom));
        end

`ifdef VIB_FRAMER_TEST_PATTERN_EN
        // Ramp pattern replaces the sum field
        tm = 1'b1;
        step(1, 0, 0, 0);
        clear_capture();
        for (int i = 0; i < 1 + DECIM_N * 3 + 2; i++) step(0, 1, 1, 12'($urandom));
        for (int k = 0; k < 3; k++) begin
            w = dut_words[k];
            chk("tp_ramp", {16'd0, w[15:0]}, 32'(k));
            chk("tp_idx",  {26'd0, w[21:16]}, 32'(k));
            chk("tp_nf",   {31'd0, dut_nf[k]}, 32'(k == 0));
        end
        tm = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vib_sample_framer.md
Name: vib_sample_framer

Overview:
- Upstream feeder for the UART driver stage.
- Takes raw vibration ADC samples, decimates them by summing 2^DECIM_LOG2 consecutive samples, and tags each sum with its index inside the frame.
- Presents each 22-bit word on i_data with a one-cycle UART_send strobe, and marks the first word of every frame with new_frame.
- Sits between the ADC capture interface and UARTDriver; its outputs connect 1:1 to UARTDriver's UART_send, new_frame and i_data.

Parameters:
- ADC_W, 12: ADC sample width, unsigned.
- DECIM_LOG2, 4: log2 of samples summed per output word.
- IDX_W, 6: width of the word-index tag. Constraint: IDX_W + ADC_W + DECIM_LOG2 == 22; a violation is an elaboration error.
- FRAME_LEN, 64: words per frame. Range 1..2^IDX_W.

Ports:
- sys_clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  capture arm (level).
- adc_valid  in  1  adc_data valid this cycle.
- adc_data  in  ADC_W  unsigned sample.
- i_data  out  22  output word {idx[IDX_W-1:0], sum[ADC_W+DECIM_LOG2-1:0]}.
- UART_send  out  1  one-cycle strobe: i_data is a new word.
- new_frame  out  1  one-cycle strobe coincident with UART_send on word idx 0.
- busy  out  1  high in RUN or DRAIN.
- frame_count  out  8  completed frames, wraps 255->0.

Behaviour:
- Reset (synchronous, active-high, same edge clears everything):
  - i_data=0, UART_send=0, new_frame=0, busy=0, frame_count=0.
  - Accumulator=0, sample count=0, idx=0, state=IDLE.
  - Reset mid-frame discards the partial sum; no strobe is issued.
- States:
  - IDLE: adc_valid ignored. enable=1 -> RUN with acc=0, cnt=0, idx=0. busy=1 from the cycle after enable is seen.
  - RUN: each adc_valid adds adc_data to acc and increments cnt.
  - DRAIN: same datapath as RUN. Entered from RUN when enable=0 at any point; the frame in progress completes all FRAME_LEN words. After the word with idx=FRAME_LEN-1 -> IDLE.
  - DRAIN with enable back at 1 before the frame ends -> RUN; no gap.
- Emit:
  - On the edge that accepts the 2^DECIM_LOG2-th valid sample: i_data <= {idx, acc+adc_data}, UART_send <= 1 for exactly one cycle, new_frame <= (idx==0).
  - Latency: 1 cycle from the final sample edge to the strobe.
  - Same edge: acc reloads to 0 and cnt to 0. The next adc_valid (even the immediately following cycle) is accumulated; no samples are lost.
- Width: sum width = ADC_W+DECIM_LOG2 bits, exact. Cannot overflow: max 16*0xFFF = 0xFFF0.
- Frame wrap:
  - After the word with idx=FRAME_LEN-1 is emitted: idx -> 0, frame_count += 1 (mod 256).
  - idx never reaches FRAME_LEN.
- Hold: i_data holds its value between strobes and is never modified except on a strobe.
- Strobe spacing: at least 2^DECIM_LOG2 cycles between strobes. This is guaranteed because at most one sample is accepted per cycle.
- adc_valid gaps: any number of idle cycles between samples is allowed; the sum is unaffected.
- Simultaneous events:
  - enable falling on the same edge as a final sample: the word is still emitted.
  - enable=0 in IDLE: the block stays idle.

Optional Feature:
- Macro: VIB_FRAMER_TEST_PATTERN_EN
- Defined: an extra input port test_mode (1 bit) is added. With test_mode=1, the sum field is replaced by a 16-bit ramp counter that increments once per emitted word (starts at 0 on reset or leaving IDLE); timing, idx, new_frame and frame_count are unchanged. Lets the PC side check link integrity without a sensor.
- Not defined: the port and ramp logic are absent; the sum field is always the accumulator.

Test Plan:
- Reset, enable=1, adc_valid=1 every cycle, adc_data=0x0F0 -> first strobe 1 cycle after the 16th sample: i_data=22'h000F00, new_frame=1. Next word 22'h010F00 with new_frame=0, and so on.
- Same stimulus for 64 words -> word 64 is i_data=22'h3F0F00; the following word is i_data=22'h000F00 with new_frame=1; frame_count=1.
- adc_data=0xFFF constant -> sum field 0xFFF0 every word, no wrap. Alternate adc_valid 1/0 -> strobes every 32 cycles, same values.
- enable dropped after word idx=10 -> words idx 11..63 still emitted; busy falls after idx=63; no further strobes while enable=0.
- reset pulsed after 7 samples of word idx=3 -> all outputs zero next cycle. Re-enable -> next word is idx=0, sum of the 16 new samples only.
- With VIB_FRAMER_TEST_PATTERN_EN defined and test_mode=1 -> sum fields 0x0000, 0x0001, 0x0002… with idx and new_frame as in the first scenario.
